// File: rtl/sort_pkg.sv
// Shared types for the 6-input sorting network and its drain stage.
package sort_pkg;

  localparam int unsigned N_LANES = 6;
  localparam int unsigned DW      = 32;

  typedef logic [DW-1:0] data_t;
  typedef logic [2:0]    lane_idx_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/sort_6_drain_if.sv
// Frame-in / beat-out handshake bundle for sort_6_drain.
// order_err exists only when SORT_DRAIN_CHECK_EN is defined.
interface sort_6_drain_if;
  import sort_pkg::*;

  logic      in_valid;
  logic      in_ready;
  data_t     in_data [N_LANES];
  logic      out_valid;
  logic      out_ready;
  data_t     out_data;
  lane_idx_t out_idx;
  logic      out_last;
`ifdef SORT_DRAIN_CHECK_EN
  logic      order_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, order_err
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, order_err
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
`endif

endinterface

// File: rtl/sort_6_drain_check.sv
// Combinational adjacent-pair monotonicity check over one 6-word frame.
module sort_6_drain_check
  import sort_pkg::*;
(
  input  data_t data [N_LANES],
  output logic  unsorted
);

  always_comb begin
    unsorted = 1'b0;
    for (int unsigned i = 0; i < N_LANES - 1; i++) begin
      if (data[i] > data[i+1]) unsorted = 1'b1;
    end
  end

endmodule

// File: rtl/sort_6_drain.sv
// Drain stage: captures a sorted 6-word frame and serialises it lane 0 first.
// Optional order checking enabled by SORT_DRAIN_CHECK_EN.
module sort_6_drain
  import sort_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  sort_6_drain_if.slave  bus
);

  localparam lane_idx_t LAST_IDX = lane_idx_t'(N_LANES - 1);

  drain_state_e state_q, state_d;
  lane_idx_t    idx_q, idx_d;
  data_t        buf_q [N_LANES];
  data_t        buf_d [N_LANES];
  logic         out_valid_q, out_valid_d;
  data_t        out_data_q, out_data_d;
  lane_idx_t    out_idx_q, out_idx_d;
  logic         out_last_q, out_last_d;

  logic         in_ready_c;
  logic         frame_acc_c;
  logic         beat_acc_c;

  // Accept a new frame while idle or on the final beat it replaces.
  assign in_ready_c  = (state_q == ST_IDLE) ||
                       ((state_q == ST_DRAIN) && (idx_q == LAST_IDX) && bus.out_ready);
  assign frame_acc_c = bus.in_valid && in_ready_c;
  assign beat_acc_c  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    if (frame_acc_c) begin
      buf_d   = bus.in_data;
      idx_d   = '0;
      state_d = ST_DRAIN;
    end else if (beat_acc_c) begin
      if (idx_q < LAST_IDX) idx_d = idx_q + lane_idx_t'(1);
      else                  state_d = ST_IDLE;
    end

    // Output registers mirror the next buffer slot so beats appear one cycle after accept.
    if (state_d == ST_DRAIN) begin
      out_valid_d = 1'b1;
      out_data_d  = buf_d[idx_d];
      out_idx_d   = idx_d;
      out_last_d  = (idx_d == LAST_IDX);
    end else begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_idx_d   = '0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      buf_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;

`ifdef SORT_DRAIN_CHECK_EN
  data_t in_data_c [N_LANES];
  logic  unsorted_c;
  logic  order_err_q, order_err_d;

  assign in_data_c = bus.in_data;

  sort_6_drain_check u_check (
    .data     (in_data_c),
    .unsorted (unsorted_c)
  );

  // Flag is latched per frame and dropped when the drain goes idle.
  always_comb begin
    order_err_d = order_err_q;
    if (frame_acc_c)                order_err_d = unsorted_c;
    else if (state_d == ST_IDLE)    order_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) order_err_q <= 1'b0;
    else        order_err_q <= order_err_d;
  end

  assign bus.order_err = order_err_q;
`endif

endmodule

// File: tb/tb_sort_6_drain.sv
// Self-checking bench for sort_6_drain: directed tables, hand sequences, random vs queue model.
module tb_sort_6_drain;
  import sort_pkg::*;

  logic clk;
  logic rst_n;

  sort_6_drain_if bus ();

  sort_6_drain u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] base;
    logic [31:0] step;
    logic        orr;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_data;
    logic [31:0] e_idx;
    logic        e_last;
  } vec_t;

  typedef struct {
    data_t d;
    int    idx;
    bit    err;
  } beat_t;

  int    n_vec;
  int    n_err;
  vec_t  vecs[$];
  beat_t model_q[$];
  data_t f [N_LANES];

  function automatic vec_t mk(logic iv, logic [31:0] base, logic [31:0] step, logic orr,
                              logic e_ir, logic e_ov, logic [31:0] e_data,
                              logic [31:0] e_idx, logic e_last);
    vec_t v;
    v.iv = iv; v.base = base; v.step = step; v.orr = orr;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_data = e_data; v.e_idx = e_idx; v.e_last = e_last;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_frame(input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < N_LANES; i++) bus.in_data[i] = base + 32'(i) * step;
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    bus.in_valid  = v.iv;
    bus.out_ready = v.orr;
    drive_frame(v.base, v.step);
    #1;
    check("tbl_in_ready", 32'(bus.in_ready), 32'(v.e_ir));
    check("tbl_out_valid", 32'(bus.out_valid), 32'(v.e_ov));
    if (v.e_ov) begin
      check("tbl_out_data", bus.out_data, v.e_data);
      check("tbl_out_idx", 32'(bus.out_idx), v.e_idx);
      check("tbl_out_last", 32'(bus.out_last), 32'(v.e_last));
    end
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_out_data"}, bus.out_data, 32'd0);
    check({name, "_out_idx"}, 32'(bus.out_idx), 32'd0);
    check({name, "_out_last"}, 32'(bus.out_last), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive_frame(32'd0, 32'd0);

    // Reset then idle
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check_idle_zero("rst");
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_idle_zero("idle");
      @(negedge clk);
    end

    // Single frame {1..6}
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(0, 0, 0, 1, k == 5, 1, 32'(k + 1), 32'(k), k == 5));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // Backpressure on beat 20 for 3 cycles
    vecs.push_back(mk(1, 10, 10, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 10, 0, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 0, 0, 0, 1, 20, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 20, 1, 0));
    for (int k = 2; k < 6; k++)
      vecs.push_back(mk(0, 0, 0, 1, k == 5, 1, 32'(10 * (k + 1)), 32'(k), k == 5));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // Back-to-back A={0..5}, B={100..105}
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1, 100, 1, 1, k == 5, 1, 32'(k), 32'(k), k == 5));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(k < 5, 100, 1, 1, k == 5, 1, 32'(100 + k), 32'(k), k == 5));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Reset mid-frame {7..12} after beat 2
    @(negedge clk);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; drive_frame(32'd7, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("mid_data", bus.out_data, 32'(7 + k));
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data", bus.out_data, 32'd0);
    check("mid_rst_out_idx", 32'(bus.out_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b1; drive_frame(32'd20, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("post_rst_data", bus.out_data, 32'(20 + k));
      check("post_rst_idx", 32'(bus.out_idx), 32'(k));
    end
    @(negedge clk);

`ifdef SORT_DRAIN_CHECK_EN
    // Unsorted frame then sorted frame
    for (int c = 0; c < 14; c++) begin
      bus.in_valid = (c == 0) || (c == 6);
      if (c == 0) begin
        bus.in_data[0] = 1; bus.in_data[1] = 3; bus.in_data[2] = 2;
        bus.in_data[3] = 4; bus.in_data[4] = 5; bus.in_data[5] = 6;
      end else if (c == 6) begin
        drive_frame(32'd1, 32'd1);
      end
      #1;
      if (c >= 1 && c <= 6)  check("order_err_unsorted", 32'(bus.order_err), 32'd1);
      if (c >= 7)            check("order_err_sorted", 32'(bus.order_err), 32'd0);
      @(negedge clk);
    end
`endif

    // Randomised traffic against a word-queue model
    model_q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic iv, orr, exp_ir, fire_in, fire_out;
      bit   err;
      @(negedge clk);
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        f[0] = data_t'($urandom_range(0, 1000));
        for (int i = 1; i < N_LANES; i++) f[i] = f[i-1] + data_t'($urandom_range(0, 50));
      end else begin
        for (int i = 0; i < N_LANES; i++) f[i] = $urandom;
      end
      bus.in_valid  = iv;
      bus.out_ready = orr;
      for (int i = 0; i < N_LANES; i++) bus.in_data[i] = f[i];
      #1;
      exp_ir = (model_q.size() == 0) || (model_q.size() == 1 && orr);
      check("rnd_in_ready", 32'(bus.in_ready), 32'(exp_ir));
      check("rnd_out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        check("rnd_out_data", bus.out_data, model_q[0].d);
        check("rnd_out_idx", 32'(bus.out_idx), 32'(model_q[0].idx));
        check("rnd_out_last", 32'(bus.out_last), 32'(model_q[0].idx == 5));
`ifdef SORT_DRAIN_CHECK_EN
        check("rnd_order_err", 32'(bus.order_err), 32'(model_q[0].err));
`endif
      end
      fire_out = (model_q.size() > 0) && orr;
      fire_in  = iv && exp_ir;
      err = 1'b0;
      for (int i = 0; i < N_LANES - 1; i++) if (f[i] > f[i+1]) err = 1'b1;
      @(posedge clk);
      if (fire_out) void'(model_q.pop_front());
      if (fire_in)
        for (int i = 0; i < N_LANES; i++) model_q.push_back('{d: f[i], idx: i, err: err});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
